// File: rtl/mem_port_arbiter.sv
// Shares one split-transaction memory port between the fetch (i_*) and data (d_*) requesters.
// Accepted owners are queued in order so data_ok/rdata return to whoever issued the request.
module mem_port_arbiter #(
    parameter int MAX_OUT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        proto_err
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_OUT);
    localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    typedef enum logic { IDLE, LOCK } state_t;
    typedef enum logic { OWN_I, OWN_D } owner_t;

    state_t        state;
    owner_t        lock_owner;
    owner_t        owner;
    owner_t        owner_q [MAX_OUT];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;
    logic          issue;
    logic          push;
    logic          pop;
    logic          pick_d;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        pick_d    = d_req && !(i_req && starve == STARVE_MAX);
        owner     = (state == LOCK) ? lock_owner : (pick_d ? OWN_D : OWN_I);
        // Issue is frozen while the FIFO is full; a same-cycle pop frees a slot only next cycle.
        issue     = rst && ((state == LOCK) || ((i_req || d_req) && count != CNT_MAX));
        push      = issue && m_addr_ok;
        pop       = rst && m_data_ok && count != '0;

        m_req     = issue;
        m_wr      = 1'b0;
        m_size    = '0;
        m_wstrb   = '0;
        m_addr    = '0;
        m_wdata   = '0;
        if (issue) begin
            if (owner == OWN_D) begin
                m_wr    = d_wr;
                m_size  = d_size;
                m_wstrb = d_wstrb;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end else begin
                m_wr    = i_wr;
                m_size  = i_size;
                m_wstrb = i_wstrb;
                m_addr  = i_addr;
                m_wdata = i_wdata;
            end
        end

        i_addr_ok = push && owner == OWN_I;
        d_addr_ok = push && owner == OWN_D;
        i_data_ok = pop && owner_q[rd_ptr] == OWN_I;
        d_data_ok = pop && owner_q[rd_ptr] == OWN_D;
        i_rdata   = i_data_ok ? m_rdata : '0;
        d_rdata   = d_data_ok ? m_rdata : '0;
    end

    // NOTE: the owner storage carries no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) owner_q[wr_ptr] <= owner;
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            lock_owner <= OWN_I;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve     <= '0;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (issue && !m_addr_ok) begin
                    lock_owner <= owner;
                    state      <= LOCK;
                end
                LOCK: if (m_addr_ok) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (!i_req || (push && owner == OWN_I))
                starve <= '0;
            else if (push && owner == OWN_D && starve != STARVE_MAX)
                starve <= starve + SW'(1);

            if (m_data_ok && count == '0) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of the arbitration and response-routing rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int MAX_OUT    = 2;
    localparam int STARVE_LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [3:0]  i_wstrb, d_wstrb;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        proto_err;

    int checks = 0;
    int fails  = 0;

    // {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}
    wire [4:0]  hs  = {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok};
    wire [70:0] fld = {m_wr, m_size, m_wstrb, m_addr, m_wdata};

    mem_port_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wstrb(i_wstrb),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 0; i_wr = 0; i_size = 0; i_wstrb = 0; i_addr = 0; i_wdata = 0;
        d_req = 0; d_wr = 0; d_size = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic test_reset();
        rst = 0; i_req = 1; d_req = 1; m_addr_ok = 1; m_data_ok = 1;
        #2;
        checks++; if (hs !== 5'b00000) begin fails++; $display("FAIL reset_hs: got %b want 00000", hs); end
        checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b want 0", proto_err); end
        next_cycle(); clear_inputs(); rst = 1;
        next_cycle(); #2;
        checks++; if (hs !== 5'b00000) begin fails++; $display("FAIL post_reset_hs: got %b want 00000", hs); end
        checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL post_reset_perr: got %b want 0", proto_err); end
    endtask

    task automatic test_single_load();
        next_cycle(); d_req = 1; d_addr = 32'h1000; d_size = 2; m_addr_ok = 1; #2;
        checks++; if (hs !== 5'b10100) begin fails++; $display("FAIL load_accept: got %b want 10100", hs); end
        checks++; if (m_addr !== 32'h1000) begin fails++; $display("FAIL load_addr: got %h want 00001000", m_addr); end
        next_cycle(); d_req = 0; m_addr_ok = 0; #2;
        checks++; if (hs !== 5'b00000) begin fails++; $display("FAIL load_gap: got %b want 00000", hs); end
        next_cycle(); m_data_ok = 1; m_rdata = 32'hDEADBEEF; #2;
        checks++; if (hs !== 5'b00001) begin fails++; $display("FAIL load_resp: got %b want 00001", hs); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL load_rdata: got %h want deadbeef", d_rdata); end
        next_cycle(); m_data_ok = 0; #2;
        checks++; if (hs !== 5'b00000) begin fails++; $display("FAIL load_idle: got %b want 00000", hs); end
    endtask

    task automatic test_contention_lock();
        next_cycle(); i_req = 1; i_addr = 32'h2000; d_req = 1; d_addr = 32'h3000; m_addr_ok = 0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (hs !== 5'b10000) begin fails++; $display("FAIL lock_hs[%0d]: got %b want 10000", c, hs); end
            checks++; if (m_addr !== 32'h3000) begin fails++; $display("FAIL lock_addr[%0d]: got %h want 00003000", c, m_addr); end
            next_cycle();
        end
        m_addr_ok = 1; #2;
        checks++; if (hs !== 5'b10100) begin fails++; $display("FAIL lock_d_win: got %b want 10100", hs); end
        checks++; if (m_addr !== 32'h3000) begin fails++; $display("FAIL lock_d_addr: got %h want 00003000", m_addr); end
        next_cycle(); d_req = 0; #2;
        checks++; if (hs !== 5'b11000) begin fails++; $display("FAIL lock_i_next: got %b want 11000", hs); end
        checks++; if (m_addr !== 32'h2000) begin fails++; $display("FAIL lock_i_addr: got %h want 00002000", m_addr); end
        next_cycle(); i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hA; #2;
        checks++; if (hs !== 5'b00001 || d_rdata !== 32'hA) begin fails++; $display("FAIL lock_resp_d: got %b/%h want 00001/0000000a", hs, d_rdata); end
        next_cycle(); m_rdata = 32'hB; #2;
        checks++; if (hs !== 5'b00010 || i_rdata !== 32'hB) begin fails++; $display("FAIL lock_resp_i: got %b/%h want 00010/0000000b", hs, i_rdata); end
        next_cycle(); m_data_ok = 0;
    endtask

    task automatic test_ordering();
        next_cycle(); i_req = 1; i_addr = 32'h0; m_addr_ok = 1; #2;
        checks++; if (hs !== 5'b11000) begin fails++; $display("FAIL order_i_acc: got %b want 11000", hs); end
        next_cycle(); i_req = 0; d_req = 1; d_addr = 32'h8; #2;
        checks++; if (hs !== 5'b10100 || m_addr !== 32'h8) begin fails++; $display("FAIL order_d_acc: got %b/%h want 10100/00000008", hs, m_addr); end
        next_cycle(); d_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h11; #2;
        checks++; if (hs !== 5'b00010 || i_rdata !== 32'h11) begin fails++; $display("FAIL order_first: got %b/%h want 00010/00000011", hs, i_rdata); end
        next_cycle(); m_rdata = 32'h22; #2;
        checks++; if (hs !== 5'b00001 || d_rdata !== 32'h22) begin fails++; $display("FAIL order_second: got %b/%h want 00001/00000022", hs, d_rdata); end
        next_cycle(); m_data_ok = 0;
    endtask

    task automatic test_full();
        next_cycle(); d_req = 1; d_addr = 32'h100; m_addr_ok = 1; #2;
        checks++; if (hs !== 5'b10100) begin fails++; $display("FAIL full_acc1: got %b want 10100", hs); end
        next_cycle(); d_addr = 32'h104; #2;
        checks++; if (hs !== 5'b10100) begin fails++; $display("FAIL full_acc2: got %b want 10100", hs); end
        next_cycle(); d_addr = 32'h108; m_data_ok = 1; m_rdata = 32'h1; #2;
        checks++; if (hs !== 5'b00001) begin fails++; $display("FAIL full_block: got %b want 00001", hs); end
        next_cycle(); m_data_ok = 0; #2;
        checks++; if (hs !== 5'b10100 || m_addr !== 32'h108) begin fails++; $display("FAIL full_resume: got %b/%h want 10100/00000108", hs, m_addr); end
        next_cycle(); d_req = 0; m_addr_ok = 0; m_data_ok = 1;
        for (int n = 0; n < 2; n++) begin
            #2;
            checks++; if (hs !== 5'b00001) begin fails++; $display("FAIL full_drain[%0d]: got %b want 00001", n, hs); end
            next_cycle();
        end
        m_data_ok = 0; #2;
        checks++; if (hs !== 5'b00000) begin fails++; $display("FAIL full_empty: got %b want 00000", hs); end
    endtask

    task automatic test_starvation();
        next_cycle(); i_req = 1; d_req = 1; i_addr = 32'h40; d_addr = 32'h80; m_addr_ok = 1;
        for (int k = 0; k <= STARVE_LIM + 1; k++) begin
            bit       gi, pi, pd;
            logic [4:0] exp_hs;
            m_data_ok = (k > 0);
            gi = (k == STARVE_LIM);
            pi = (k > 0) && (k - 1 == STARVE_LIM);
            pd = (k > 0) && !pi;
            exp_hs = {1'b1, gi, !gi, pi, pd};
            #2;
            checks++; if (hs !== exp_hs) begin fails++; $display("FAIL starve_hs[%0d]: got %b want %b", k, hs, exp_hs); end
            checks++; if (m_addr !== (gi ? 32'h40 : 32'h80)) begin fails++; $display("FAIL starve_addr[%0d]: got %h want %h", k, m_addr, gi ? 32'h40 : 32'h80); end
            next_cycle();
        end
        i_req = 0; d_req = 0; m_addr_ok = 0; m_data_ok = 1; #2;
        checks++; if (hs !== 5'b00001) begin fails++; $display("FAIL starve_drain: got %b want 00001", hs); end
        next_cycle(); m_data_ok = 0;
    endtask

    task automatic test_proto_err_reset();
        next_cycle(); m_data_ok = 1; #2;
        checks++; if (hs !== 5'b00000) begin fails++; $display("FAIL perr_no_resp: got %b want 00000", hs); end
        next_cycle(); m_data_ok = 0; #2;
        checks++; if (proto_err !== 1'b1) begin fails++; $display("FAIL perr_set: got %b want 1", proto_err); end
        next_cycle(); d_req = 1; d_addr = 32'h200; m_addr_ok = 1; #2;
        checks++; if (proto_err !== 1'b1 || hs !== 5'b10100) begin fails++; $display("FAIL perr_sticky: got %b/%b want 1/10100", proto_err, hs); end
        next_cycle(); #2;
        checks++; if (hs !== 5'b10100) begin fails++; $display("FAIL perr_acc2: got %b want 10100", hs); end
        next_cycle(); d_req = 0; m_addr_ok = 0; rst = 0; m_data_ok = 1; #2;
        checks++; if (hs !== 5'b00000) begin fails++; $display("FAIL rst_outputs: got %b want 00000", hs); end
        next_cycle(); rst = 1; m_data_ok = 0; #2;
        checks++; if (proto_err !== 1'b0 || hs !== 5'b00000) begin fails++; $display("FAIL rst_clear: got %b/%b want 0/00000", proto_err, hs); end
        next_cycle(); m_data_ok = 1; #2;
        checks++; if (hs !== 5'b00000) begin fails++; $display("FAIL rst_discard: got %b want 00000", hs); end
        next_cycle(); m_data_ok = 0; #2;
        checks++; if (proto_err !== 1'b1) begin fails++; $display("FAIL rst_stale_resp: got %b want 1", proto_err); end
        next_cycle(); rst = 0;
        next_cycle(); rst = 1; #2;
        checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL rst_again: got %b want 0", proto_err); end
    endtask

    task automatic test_random(input int cycles);
        int   q[$];
        int   lock = -1;
        int   starve = 0;
        bit   perr = 0;
        bit   i_pend = 0, d_pend = 0;
        for (int n = 0; n < cycles; n++) begin
            bit          mreq, own_d, acc, pop_v, head_d;
            logic [4:0]  exp_hs;
            logic [70:0] exp_fld;
            next_cycle();
            if (!i_pend) begin
                i_req = 0;
                if ($urandom_range(0, 2) == 0) begin
                    i_pend = 1; i_req = 1; i_wr = 1'($urandom); i_size = 2'($urandom_range(0, 2));
                    i_wstrb = 4'($urandom); i_addr = $urandom; i_wdata = $urandom;
                end
            end
            if (!d_pend) begin
                d_req = 0;
                if ($urandom_range(0, 2) == 0) begin
                    d_pend = 1; d_req = 1; d_wr = 1'($urandom); d_size = 2'($urandom_range(0, 2));
                    d_wstrb = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
                end
            end
            m_addr_ok = 1'($urandom_range(0, 1));
            m_data_ok = (q.size() > 0) && ($urandom_range(0, 4) < 2);
            m_rdata   = $urandom;

            if (lock >= 0) begin
                mreq = 1; own_d = (lock == 1);
            end else if ((i_req || d_req) && q.size() < MAX_OUT) begin
                mreq = 1; own_d = d_req && !(i_req && starve == STARVE_LIM);
            end else begin
                mreq = 0; own_d = 0;
            end
            acc    = mreq && m_addr_ok;
            pop_v  = m_data_ok && q.size() > 0;
            head_d = pop_v && q[0] == 1;
            exp_hs = {mreq, acc && !own_d, acc && own_d, pop_v && !head_d, pop_v && head_d};
            exp_fld = own_d ? {d_wr, d_size, d_wstrb, d_addr, d_wdata}
                            : {i_wr, i_size, i_wstrb, i_addr, i_wdata};
            #2;
            checks++; if (hs !== exp_hs) begin fails++; $display("FAIL rand_hs[%0d]: got %b want %b", n, hs, exp_hs); end
            if (mreq) begin
                checks++; if (fld !== exp_fld) begin fails++; $display("FAIL rand_fields[%0d]: got %h want %h", n, fld, exp_fld); end
            end
            if (pop_v) begin
                checks++;
                if ((head_d ? d_rdata : i_rdata) !== m_rdata) begin
                    fails++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, head_d ? d_rdata : i_rdata, m_rdata);
                end
            end
            checks++; if (proto_err !== perr) begin fails++; $display("FAIL rand_perr[%0d]: got %b want %b", n, proto_err, perr); end

            if (m_data_ok && q.size() == 0) perr = 1;
            if (pop_v) void'(q.pop_front());
            if (acc) q.push_back(int'(own_d));
            if (acc) lock = -1;
            else if (mreq && lock < 0) lock = int'(own_d);
            if (!i_req || (acc && !own_d)) starve = 0;
            else if (acc && own_d && starve < STARVE_LIM) starve++;
            if (acc && !own_d) i_pend = 0;
            if (acc && own_d) d_pend = 0;
        end
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_load();
        test_contention_lock();
        test_ordering();
        test_full();
        test_starvation();
        test_proto_err_reset();
        clear_inputs();
        test_random(1500);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
